// File: rtl/clk_rate_ctrl_if.sv
// Button inputs and run-control outputs of clk_rate_ctrl, bundled for the
// board harness; the harness side drives buttons, the controller drives the rest.
interface clk_rate_ctrl_if #(
  parameter int NUM_LEVELS = 8
);
  localparam int LVL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1;

  logic             btn_faster;
  logic             btn_slower;
  logic             btn_pause;
  logic             btn_step;
  logic             clk_N;
  logic             tick;
  logic             paused;
  logic [LVL_W-1:0] curr_level;

  modport master (
    output btn_faster, btn_slower, btn_pause, btn_step,
    input  clk_N, tick, paused, curr_level
  );

  modport slave (
    input  btn_faster, btn_slower, btn_pause, btn_step,
    output clk_N, tick, paused, curr_level
  );
endinterface

// File: rtl/clk_rate_ctrl.sv
// Run-control clock generator: divides clk into clk_N at a button-selected speed
// level, with debounced run/pause, single-step and a tick aligned to clk_N rises.
module clk_rate_ctrl #(
  parameter int NUM_LEVELS       = 8,
  parameter int BASE_HALF_PERIOD = 50_000_000,
  parameter int TOP_HALF_PERIOD  = 2,
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int CNT_W            = 32,
  parameter int RESET_LEVEL      = 0
) (
  input logic           clk,
  input logic           rst,
  clk_rate_ctrl_if.slave bus
);
  localparam int LVL_W = (NUM_LEVELS > 2) ? $clog2(NUM_LEVELS) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int B_FASTER = 0;
  localparam int B_SLOWER = 1;
  localparam int B_PAUSE  = 2;
  localparam int B_STEP   = 3;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED, STEP} state_t;

  logic [3:0]       raw;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db;
  logic [3:0]       ev;
  logic [DB_W-1:0]  db_cnt [4];

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic             wrap;
  logic             clk_div;
  logic             tick_r;
  logic             paused_r;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_next;
  logic             level_change;

  function automatic logic [CNT_W-1:0] half_of(input logic [LVL_W-1:0] l);
    logic [31:0] h;
    if (32'(l) == NUM_LEVELS - 1) h = TOP_HALF_PERIOD;
    else                          h = BASE_HALF_PERIOD >> l;
    if (h == 32'd0) h = 32'd1;
    return CNT_W'(h);
  endfunction

  assign raw  = {bus.btn_step, bus.btn_pause, bus.btn_slower, bus.btn_faster};
  assign half = half_of(level);
  assign wrap = (cnt >= half - CNT_W'(1));

  // Each button: 2-flop synchroniser, then a stable-count debouncer; ev pulses
  // for one cycle on the debounced rising edge only.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      ev    <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
            ev[i]     <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    level_next = level;
    if (ev[B_FASTER] && !ev[B_SLOWER] && level != LVL_MAX)
      level_next = level + LVL_W'(1);
    else if (ev[B_SLOWER] && !ev[B_FASTER] && level != '0)
      level_next = level - LVL_W'(1);
  end

  assign level_change = (level_next != level);

  // Run-control FSM; a level change restarts the half-period with clk_N held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      clk_div  <= 1'b0;
      tick_r   <= 1'b0;
      paused_r <= 1'b0;
      level    <= LVL_W'(RESET_LEVEL);
    end else begin
      tick_r <= 1'b0;
      level  <= level_next;
      case (state)
        PAUSED: begin
          cnt     <= '0;
          clk_div <= 1'b0;
          if (ev[B_PAUSE]) begin
            state    <= RUN;
            paused_r <= 1'b0;
          end else if (ev[B_STEP]) begin
            state   <= STEP;
            clk_div <= 1'b1;
            tick_r  <= 1'b1;
          end
        end
        default: begin
          if (level_change) begin
            cnt <= '0;
          end else if (wrap) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
            tick_r  <= ~clk_div;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end

          if (ev[B_PAUSE]) begin
            if (state == RUN) begin
              state <= DRAIN;
            end else begin
              state    <= RUN;
              paused_r <= 1'b0;
            end
          end else if (state != RUN && !level_change && wrap && clk_div) begin
            state    <= PAUSED;
            paused_r <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.clk_N      = clk_div;
  assign bus.tick       = tick_r;
  assign bus.paused     = paused_r;
  assign bus.curr_level = level;
endmodule

// File: doc/clk_rate_ctrl.md
# clk_rate_ctrl

- Parametrised run-control clock generator for the board-level CPU harness; successor to the fixed six-level speed switcher.
- Divides `clk` into a slow `clk_N` whose speed is selected from `NUM_LEVELS` levels by debounced faster/slower buttons.
- Adds run/pause, single-step (exactly one `clk_N` period per press) and a one-cycle `tick` enable aligned to each `clk_N` rising edge.

## Interface

- `NUM_LEVELS`, 8, number of speed levels, 2..16
- `BASE_HALF_PERIOD`, 50_000_000, `clk_N` half-period in `clk` cycles at level 0
- `TOP_HALF_PERIOD`, 2, half-period at level `NUM_LEVELS-1`
- `DEBOUNCE_CYCLES`, 1_000_000, required stable cycles per button, ≥1
- `CNT_W`, 32, half-period counter width
- `RESET_LEVEL`, 0, level loaded on reset
- `clk`  in  1  system clock; everything is in this domain
- `rst`  in  1  reset; synchronous, active-high
- `btn_faster`, `btn_slower`, `btn_pause`, `btn_step`  in  1 each  raw asynchronous push-buttons, active-high
- `clk_N`  out  1  divided clock, registered
- `tick`  out  1  high for the single `clk` cycle in which `clk_N` first reads 1
- `paused`  out  1  high in PAUSED and STEP
- `curr_level`  out  LVL_W = max(1, clog2(NUM_LEVELS))  current level

## Operation

- **Half-period:**
  - H(L) = `BASE_HALF_PERIOD >> L` for L < `NUM_LEVELS-1`.
  - H(`NUM_LEVELS-1`) = `TOP_HALF_PERIOD`.
  - Any H < 1 is clamped to 1.
- **Counter:**
  - While enabled, the counter counts 0..H-1.
  - At H-1 it wraps to 0 and `clk_N` toggles, so the `clk_N` period is 2·H(L).
- **Button conditioning (per button):**
  - 2-flop synchroniser.
  - Debouncer: the debounced state changes once the synchronised value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - An event is the debounced rising edge, one per press. Releases generate nothing.
- **Level:**
  - A faster event increments the level, saturating at `NUM_LEVELS-1`.
  - A slower event decrements it, saturating at 0.
  - Faster and slower events in the same cycle leave the level unchanged.
  - Any actual level change resets the counter to 0 and holds `clk_N`, so the new half-period starts cleanly.
- **State machine:**
  - RUN: counter enabled. A pause event goes to DRAIN.
  - DRAIN: counter enabled. On the toggle that drives `clk_N` to 0, go to PAUSED. If `clk_N` is already 0 at entry, run until the next 1→0 toggle. A pause event here returns to RUN.
  - PAUSED: counter held at 0 and `clk_N` = 0.
    - Pause event → RUN, counting from 0.
    - Step event → STEP: `clk_N` is set to 1 on the next edge and `tick` fires.
  - STEP: counter enabled. After H(L) cycles `clk_N` goes to 0 and the state returns to PAUSED.
    - Step events are ignored.
    - A pause event → RUN (no glitch, count continues).
- **Other event rules:**
  - Step events in RUN and DRAIN are ignored.
  - A level event and a pause/step event in the same cycle are both applied.
- **`tick`:** registered together with every 0→1 transition of `clk_N`, in all states.

## Timing

- **Reset values** (all take effect on the reset edge):
  - `clk_N`=0, `tick`=0, `paused`=0, `curr_level`=`RESET_LEVEL`.
  - Counter=0, state RUN.
  - Synchronisers, debounced states and debounce counters all 0.
- **Reset mid-operation** (DRAIN, STEP, in the middle of a debounce) fully aborts; the first edge after `rst` falls behaves as RUN from counter 0.
- A button held through reset produces one event after release of `rst`, with normal debounce latency.
- **Button latency:** raw input high before edge 0 and held → its effect (level, `paused`, `clk_N`) is visible after edge `DEBOUNCE_CYCLES`+2.
- A raw pulse shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no event.
- **Clock timing:**
  - After reset at level L, the first `clk_N` rise is on edge H(L); `tick` is high for that one cycle.
  - PAUSED → STEP: `clk_N` rises one edge after the step event and stays high exactly H(L) cycles.

## Test plan

Bench parameters: `NUM_LEVELS`=4, `BASE_HALF_PERIOD`=8, `TOP_HALF_PERIOD`=1, `DEBOUNCE_CYCLES`=3, giving H = 8/4/2/1.

- **Free run:** reset, then run 64 cycles → `clk_N` rises at edges 8, 24, 40, 56; `tick` is high only in those 4 cycles.
- **Faster presses and bounce:**
  - `btn_faster` held 10 cycles, repeated 4 times with 10-cycle gaps → `curr_level` = 1, 2, 3, 3; the final `clk_N` period is 2 cycles.
  - A 2-cycle `btn_faster` pulse → no level change.
- **Simultaneous buttons:** `btn_faster` and `btn_slower` rise together and are held 10 cycles at level 2 → `curr_level` stays 2 and the counter is not reset.
- **Pause and step at level 1:**
  - Pause press → `clk_N` completes to 0, then `paused`=1 and `clk_N` stays 0 for 40 cycles.
  - Step press → `clk_N` high exactly 4 cycles with one `tick`, then 0.
  - A second step press during STEP → no extra pulse.
- **Pause/resume and step in RUN:**
  - Pause in PAUSED → `paused`=0 and `clk_N` rises 4 cycles later.
  - Step in RUN → ignored.
- **Reset mid-STEP at level 2:** assert `rst` for 1 cycle → next edge gives `clk_N`=0, `paused`=0, `curr_level`=0; the first rise follows 8 cycles later.
